// File: rtl/vpe_pkg.sv
// rtl/vpe_pkg.sv - shared FSM states, LFSR constants and saturating add for the VPE master
package vpe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCAL  = 2'd1,
        ACCUM  = 2'd2,
        UPDATE = 2'd3
    } vpeState_t;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic signed [31:0] satAdd(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 sumW
    );
        logic signed [32:0] s;
        logic signed [32:0] maxV;
        logic signed [32:0] minV;
        s    = {a[31], a} + {b[31], b};
        maxV = (33'sd1 <<< (sumW - 1)) - 33'sd1;
        minV = -(33'sd1 <<< (sumW - 1));
        if (s > maxV)
            return maxV[31:0];
        else if (s < minV)
            return minV[31:0];
        else
            return s[31:0];
    endfunction

endpackage

// File: rtl/vpe_vote_sum.sv
// rtl/vpe_vote_sum.sv - combinational signed vote reduction of clause occupancy/polarity
module vpe_vote_sum #(
    parameter int N_CLAUSE = 32,
    parameter int SUM_W    = 8
) (
    input  logic [N_CLAUSE-1:0]     c0,
    input  logic [N_CLAUSE-1:0]     c1,
    output logic signed [SUM_W-1:0] voteSum
);

    localparam logic signed [SUM_W-1:0] ONE = SUM_W'(1);

    always_comb begin
        voteSum = '0;
        for (int i = 0; i < N_CLAUSE; i++) begin
            if (c0[i])
                voteSum = c1[i] ? voteSum - ONE : voteSum + ONE;
        end
    end

endmodule

// File: rtl/vpe_master_acc.sv
// rtl/vpe_master_acc.sv - VPE master: local vote + slave accumulation, variable update, satisfy chain
// Optional LFSR tie-break on a zero vote enabled by defining VPE_LFSR_TIEBREAK_EN.
module vpe_master_acc
    import vpe_pkg::*;
#(
    parameter int N_CLAUSE = 32,
    parameter int N_SLAVE  = 1,
    parameter int SUM_W    = 8
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    START,
    input  logic                    VAR_LOAD,
    input  logic                    V_PRE,
    input  logic [N_CLAUSE-1:0]     C0,
    input  logic [N_CLAUSE-1:0]     C1,
    input  logic                    SLV_VALID,
    input  logic [SUM_W-1:0]        SLV_SUM,
    output logic                    SLV_READY,
    input  logic                    SATISFY_UP,
    input  logic                    SATISFY_LEFT,
    output logic                    VI,
    output logic [SUM_W-1:0]        SUM_OUT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    SATISFY
);

    localparam int CNT_W = (N_SLAVE > 1) ? $clog2(N_SLAVE + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_SLV = CNT_W'((N_SLAVE > 0) ? N_SLAVE - 1 : 0);

    if (SUM_W < $clog2(N_CLAUSE) + 2) begin : gSumWCheck
        $error("vpe_master_acc: SUM_W too narrow for N_CLAUSE");
    end

    vpeState_t               state;
    vpeState_t               nextState;
    logic signed [SUM_W-1:0] localSum;
    logic signed [SUM_W-1:0] acc;
    logic signed [SUM_W-1:0] sumOut;
    logic signed [SUM_W-1:0] slvSum;
    logic [CNT_W-1:0]        slvCnt;
    logic                    vi;
    logic                    doneReg;
    logic                    satisfyReg;
    logic                    slvFire;

    vpe_vote_sum #(
        .N_CLAUSE(N_CLAUSE),
        .SUM_W   (SUM_W)
    ) uVoteSum (
        .c0     (C0),
        .c1     (C1),
        .voteSum(localSum)
    );

    assign slvSum    = SLV_SUM;
    assign slvFire   = (state == ACCUM) && SLV_VALID;
    assign SLV_READY = (state == ACCUM);
    assign BUSY      = (state != IDLE);
    assign VI        = vi;
    assign SUM_OUT   = sumOut;
    assign DONE      = doneReg;
    assign SATISFY   = satisfyReg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (START && !VAR_LOAD) nextState = LOCAL;
            LOCAL:   nextState = (N_SLAVE > 0) ? ACCUM : UPDATE;
            ACCUM:   if (slvFire && slvCnt == LAST_SLV) nextState = UPDATE;
            UPDATE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

`ifdef VPE_LFSR_TIEBREAK_EN
    logic [15:0] lfsr;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            lfsr <= LFSR_SEED;
        else if (state == UPDATE)
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc        <= '0;
            slvCnt     <= '0;
            sumOut     <= '0;
            vi         <= 1'b0;
            doneReg    <= 1'b0;
            satisfyReg <= 1'b0;
        end else begin
            doneReg    <= (state == UPDATE);
            // satisfy looks at the registered variable, so it trails a VI change by a cycle
            satisfyReg <= (&(~C0 | (C1 ^ {N_CLAUSE{vi}}))) & SATISFY_UP & SATISFY_LEFT;
            case (state)
                IDLE: begin
                    if (VAR_LOAD)
                        vi <= V_PRE;
                end
                LOCAL: begin
                    acc    <= localSum;
                    slvCnt <= '0;
                end
                ACCUM: begin
                    if (slvFire) begin
                        acc    <= SUM_W'(satAdd(32'(acc), 32'(slvSum), SUM_W));
                        slvCnt <= slvCnt + CNT_W'(1);
                    end
                end
                UPDATE: begin
                    sumOut <= acc;
                    if (acc[SUM_W-1])
                        vi <= 1'b0;
                    else if (acc != '0)
                        vi <= 1'b1;
`ifdef VPE_LFSR_TIEBREAK_EN
                    else
                        vi <= lfsr[0];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
